// File: rtl/jedro_1_imem_loader.sv
// jedro_1_imem_loader
// Streams a program image into the jedro_1 instruction RAM while the core is
// held in reset, then releases the core a fixed number of cycles after the
// last word has been committed.

module jedro_1_imem_loader #(
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           MEM_DEPTH     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned           RELEASE_DELAY = 3
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        load_start_i,
    input  logic [$clog2(MEM_DEPTH):0]  load_len_i,
    input  logic                        word_valid_i,
    input  logic [DATA_WIDTH-1:0]       word_data_i,
    output logic                        word_ready_o,
    output logic                        mem_we_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    output logic                        core_rstn_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int unsigned LEN_W  = $clog2(MEM_DEPTH) + 1;
    localparam int unsigned HOLD_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MEM_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    count;
    logic [LEN_W-1:0]    len;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [LEN_W-1:0]    count_inc;
    logic                accept;
    logic                start_ok;
    logic                start_bad;

    // Next word index, handshake and start classification.
    assign count_inc = count + LEN_ONE;
    assign accept    = word_valid_i & word_ready_o;
    assign start_bad = load_start_i & (load_len_i > MAX_LEN);
    assign start_ok  = load_start_i & ~(load_len_i > MAX_LEN);

    // Loader FSM; every output is registered so the core reset never glitches.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            count        <= '0;
            len          <= '0;
            hold_cnt     <= '0;
            word_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= BASE_ADDR;
            mem_wdata_o  <= '0;
            core_rstn_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            done_o   <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    if (start_bad) begin
                        err_o <= 1'b1;
                    end else if (start_ok) begin
                        err_o       <= 1'b0;
                        core_rstn_o <= 1'b0;
                        busy_o      <= 1'b1;
                        count       <= '0;
                        hold_cnt    <= '0;
                        if (load_len_i == '0) begin
                            state        <= HOLD;
                            word_ready_o <= 1'b0;
                        end else begin
                            state        <= LOAD;
                            len          <= load_len_i;
                            word_ready_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= BASE_ADDR + (ADDR_WIDTH'(count) << 2);
                        mem_wdata_o <= word_data_i;
                        count       <= count_inc;
                        if (count_inc == len) begin
                            state        <= HOLD;
                            word_ready_o <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        busy_o      <= 1'b0;
                        core_rstn_o <= 1'b1;
                        done_o      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_imem_loader.sv
// tb_jedro_1_imem_loader
// Self-checking bench: a timeline-level model of the loader is compared with
// the DUT every cycle, plus directed scenarios with hand-computed literals.

module tb_jedro_1_imem_loader;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned MEM_DEPTH     = 1024;
    localparam logic [31:0] BASE          = 32'h0;
    localparam int unsigned RELEASE_DELAY = 3;
    localparam int unsigned LEN_W         = $clog2(MEM_DEPTH) + 1;

    logic                  clk_i        = 1'b0;
    logic                  rstn_i       = 1'b0;
    logic                  load_start_i = 1'b0;
    logic [LEN_W-1:0]      load_len_i   = '0;
    logic                  word_valid_i = 1'b0;
    logic [DATA_WIDTH-1:0] word_data_i  = '0;
    logic                  word_ready_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  core_rstn_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] src [0:MEM_DEPTH-1];
    logic [31:0] img [0:MEM_DEPTH-1];
    int          write_count = 0;
    int          done_seen   = 0;
    logic [31:0] first_addr  = '0;
    logic [31:0] last_addr   = '0;

    // Behavioural model: expected outputs derived from a timeline of events
    bit          m_loading = 1'b0;
    bit          m_we      = 1'b0;
    bit          m_core    = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_data    = '0;
    int          m_len     = 0;
    int          m_acc     = 0;
    longint      m_cyc     = 0;
    longint      m_release = -1;

    jedro_1_imem_loader #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MEM_DEPTH     (MEM_DEPTH),
        .BASE_ADDR     (BASE),
        .RELEASE_DELAY (RELEASE_DELAY)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .word_valid_i (word_valid_i),
        .word_data_i  (word_data_i),
        .word_ready_o (word_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rstn_o  (core_rstn_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Free-running clock.
    initial forever #5 clk_i = ~clk_i;

    // Hard stop in case something wedges the stimulus.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit start, input int len, input bit valid, input logic [31:0] data);
        load_start_i = start;
        load_len_i   = LEN_W'(len);
        word_valid_i = valid;
        word_data_i  = data;
    endtask

    // One-cycle start pulse; returns in the cycle after the start edge.
    task automatic startLoad(input int len);
        write_count = 0;
        done_seen   = 0;
        applyStimulus(1'b1, len, 1'b0, 32'h0);
        @(negedge clk_i);
        applyStimulus(1'b0, 0, 1'b0, 32'h0);
    endtask

    // Feed src[0..n-1]; returns in the cycle after the last acceptance edge.
    task automatic streamWords(input int n, input bit toggle, input int budget);
        int  idx = 0;
        int  k   = 0;
        bit  acc;
        while (idx < n && k < budget) begin
            applyStimulus(1'b0, 0, toggle ? (k % 2 == 0) : 1'b1, src[idx]);
            acc = word_valid_i && word_ready_o;
            @(negedge clk_i);
            k++;
            if (acc) idx++;
        end
        applyStimulus(1'b0, 0, 1'b0, 32'h0);
        checkOutput("stream_complete", 64'(idx), 64'(n));
    endtask

    task automatic clearImage();
        for (int i = 0; i < MEM_DEPTH; i++) img[i] = 32'h0;
    endtask

    // Model step: advance the timeline by one clock edge.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_loading = 1'b0;
            m_we      = 1'b0;
            m_core    = 1'b0;
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_len     = 0;
            m_acc     = 0;
            m_release = -1;
        end else begin
            m_cyc++;
            m_we   = 1'b0;
            m_done = 1'b0;
            if (m_release == m_cyc) begin
                m_release = -1;
                m_core    = 1'b1;
                m_done    = 1'b1;
                m_busy    = 1'b0;
            end else if (!m_busy && load_start_i) begin
                if (int'(load_len_i) > int'(MEM_DEPTH)) begin
                    m_err = 1'b1;
                end else begin
                    m_err  = 1'b0;
                    m_core = 1'b0;
                    m_busy = 1'b1;
                    if (load_len_i == '0) begin
                        m_release = m_cyc + RELEASE_DELAY;
                    end else begin
                        m_loading = 1'b1;
                        m_len     = int'(load_len_i);
                        m_acc     = 0;
                    end
                end
            end else if (m_loading && word_valid_i) begin
                m_we   = 1'b1;
                m_addr = BASE + 32'(4 * m_acc);
                m_data = word_data_i;
                m_acc++;
                if (m_acc == m_len) begin
                    m_loading = 1'b0;
                    m_release = m_cyc + RELEASE_DELAY;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a write scoreboard.
    always @(negedge clk_i) begin
        checkOutput("word_ready", 64'(word_ready_o), 64'(m_loading));
        checkOutput("mem_we", 64'(mem_we_o), 64'(m_we));
        if (m_we) begin
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(m_addr));
            checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(m_data));
        end
        checkOutput("core_rstn", 64'(core_rstn_o), 64'(m_core));
        checkOutput("busy", 64'(busy_o), 64'(m_busy));
        checkOutput("done", 64'(done_o), 64'(m_done));
        checkOutput("err", 64'(err_o), 64'(m_err));
        if (mem_we_o === 1'b1) begin
            img[int'((mem_addr_o - BASE) >> 2) % MEM_DEPTH] = mem_wdata_o;
            if (write_count == 0) first_addr = mem_addr_o;
            last_addr = mem_addr_o;
            write_count++;
        end
        if (done_o === 1'b1) done_seen++;
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        applyStimulus(1'b0, 0, 1'b0, 32'h0);
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_ready", 64'(word_ready_o), 64'd0);
        checkOutput("rst_we", 64'(mem_we_o), 64'd0);
        checkOutput("rst_addr", 64'(mem_addr_o), 64'(BASE));
        checkOutput("rst_wdata", 64'(mem_wdata_o), 64'd0);
        checkOutput("rst_core", 64'(core_rstn_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        rstn_i = 1'b1;

        // Valid while idle must be ignored
        applyStimulus(1'b0, 0, 1'b1, 32'hDEADBEEF);
        repeat (3) @(negedge clk_i);
        checkOutput("idle_valid_writes", 64'(write_count), 64'd0);

        // Four words back-to-back
        src[0] = 32'h00500293; src[1] = 32'h0052F293;
        src[2] = 32'h00000013; src[3] = 32'hFFFFFFFF;
        clearImage();
        startLoad(4);
        checkOutput("t1_busy", 64'(busy_o), 64'd1);
        checkOutput("t1_ready", 64'(word_ready_o), 64'd1);
        streamWords(4, 1'b0, 50);
        checkOutput("t1_last_we", 64'(mem_we_o), 64'd1);
        checkOutput("t1_last_addr", 64'(mem_addr_o), 64'hC);
        checkOutput("t1_model_addr", 64'(m_addr), 64'hC);
        checkOutput("t1_core_n1", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t1_core_n2", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t1_core_n3", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t1_core_n4", 64'(core_rstn_o), 64'd1);
        checkOutput("t1_done_n4", 64'(done_o), 64'd1);
        @(negedge clk_i);
        checkOutput("t1_done_n5", 64'(done_o), 64'd0);
        checkOutput("t1_writes", 64'(write_count), 64'd4);
        checkOutput("t1_done_once", 64'(done_seen), 64'd1);
        for (int i = 0; i < 4; i++) checkOutput("t1_img", 64'(img[i]), 64'(src[i]));
        checkOutput("t1_img3_literal", 64'(img[3]), 64'hFFFFFFFF);

        // Same words with toggling valid, then valid held with ready low
        clearImage();
        startLoad(4);
        streamWords(4, 1'b1, 50);
        applyStimulus(1'b0, 0, 1'b1, 32'h12345678);
        repeat (6) @(negedge clk_i);
        applyStimulus(1'b0, 0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkOutput("t2_writes", 64'(write_count), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("t2_img", 64'(img[i]), 64'(src[i]));
        checkOutput("t2_core", 64'(core_rstn_o), 64'd1);

        // Zero-length load from RUN
        startLoad(0);
        checkOutput("t3_core_n1", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t3_core_n2", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t3_core_n3", 64'(core_rstn_o), 64'd0);
        @(negedge clk_i);
        checkOutput("t3_core_n4", 64'(core_rstn_o), 64'd1);
        checkOutput("t3_writes", 64'(write_count), 64'd0);

        // Rejected start in RUN keeps the core running
        startLoad(2000);
        checkOutput("t4_err", 64'(err_o), 64'd1);
        checkOutput("t4_core", 64'(core_rstn_o), 64'd1);

        // Restart from RUN with one word
        src[0] = 32'hA5A5F00D;
        startLoad(1);
        checkOutput("t5_core_drop", 64'(core_rstn_o), 64'd0);
        checkOutput("t5_err_clear", 64'(err_o), 64'd0);
        streamWords(1, 1'b0, 20);
        repeat (3) @(negedge clk_i);
        checkOutput("t5_core", 64'(core_rstn_o), 64'd1);
        checkOutput("t5_writes", 64'(write_count), 64'd1);
        checkOutput("t5_first_addr", 64'(first_addr), 64'(BASE));

        // Reset after two of four words
        src[0] = 32'h11111111; src[1] = 32'h22222222;
        src[2] = 32'h33333333; src[3] = 32'h44444444;
        startLoad(4);
        streamWords(2, 1'b0, 20);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("t6_ready", 64'(word_ready_o), 64'd0);
        checkOutput("t6_we", 64'(mem_we_o), 64'd0);
        checkOutput("t6_addr", 64'(mem_addr_o), 64'(BASE));
        checkOutput("t6_core", 64'(core_rstn_o), 64'd0);
        checkOutput("t6_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Oversized length from IDLE, then a valid start clears the error
        startLoad(MEM_DEPTH + 1);
        checkOutput("t7_err", 64'(err_o), 64'd1);
        checkOutput("t7_busy", 64'(busy_o), 64'd0);
        applyStimulus(1'b0, 0, 1'b1, 32'hCAFEBABE);
        repeat (3) @(negedge clk_i);
        checkOutput("t7_writes", 64'(write_count), 64'd0);
        checkOutput("t7_core", 64'(core_rstn_o), 64'd0);
        clearImage();
        startLoad(2);
        checkOutput("t7_err_clear", 64'(err_o), 64'd0);
        streamWords(2, 1'b0, 20);
        repeat (4) @(negedge clk_i);
        checkOutput("t7_first_addr", 64'(first_addr), 64'(BASE));
        checkOutput("t7_img1", 64'(img[1]), 64'h22222222);
        checkOutput("t7_core_run", 64'(core_rstn_o), 64'd1);

        // Full-depth image
        for (int i = 0; i < MEM_DEPTH; i++) src[i] = $urandom;
        startLoad(MEM_DEPTH);
        streamWords(MEM_DEPTH, 1'b0, 2000);
        checkOutput("t8_last_addr", 64'(mem_addr_o), 64'hFFC);
        repeat (3) @(negedge clk_i);
        checkOutput("t8_core", 64'(core_rstn_o), 64'd1);
        checkOutput("t8_writes", 64'(write_count), 64'(MEM_DEPTH));
        checkOutput("t8_img_last", 64'(img[MEM_DEPTH-1]), 64'(src[MEM_DEPTH-1]));

        // Randomized soak; the per-cycle compare does the checking
        for (int c = 0; c < 4000; c++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(MEM_DEPTH + 1, 2047);
            else len = $urandom_range(1, 12);
            applyStimulus($urandom_range(0, 14) == 0, len, $urandom_range(0, 2) != 0, $urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 rstn_i = 1'b0;
                @(negedge clk_i);
                rstn_i = 1'b1;
            end else begin
                @(negedge clk_i);
            end
        end
        applyStimulus(1'b0, 0, 1'b0, 32'h0);
        repeat (5) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
